// File: rtl/bcd_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter:
// digit limits, the digit type and a validity check used on parallel loads.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter. Purely combinational: given the current
// digit, a step request and the direction, it produces the digit's next
// value and a carry (counting up) or borrow (counting down) for the next decade.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       step_in,
    input  logic       up,
    input  bcd_digit_t digit,
    output bcd_digit_t next_digit,
    output logic       carry_out
);

    // Increment/decrement with decimal roll-over; the carry only ripples on a step.
    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (step_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    next_digit = BCD_MIN;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_MIN) begin
                    next_digit = BCD_MAX;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with step prescaler,
// validated parallel load, terminal-count pulse and load-error pulse.
// Optional build macro BCD_SATURATE_EN: when defined the count holds at
// all-9s (up) or zero (down) instead of wrapping, pulsing tc on every
// step attempt at the limit.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [4*DIGITS-1:0] r_count;
    logic [PW-1:0]       r_presc;
    logic                r_tc;
    logic                r_loadErr;

    logic                w_step;
    logic                w_loadOk;
    logic [DIGITS:0]     w_carry;
    logic [4*DIGITS-1:0] w_next;

    assign w_step     = en && (r_presc == PRESC_LAST);
    assign w_carry[0] = w_step;

    // Ripple the step through the decades; the final carry marks a wrap.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .step_in    (w_carry[i]),
            .up         (up),
            .digit      (r_count[4*i +: 4]),
            .next_digit (w_next[4*i +: 4]),
            .carry_out  (w_carry[i+1])
        );
    end

    // A load is accepted only if every nibble is a decimal digit.
    always_comb begin
        w_loadOk = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) begin
                w_loadOk = 1'b0;
            end
        end
    end

    // Count register, prescaler and pulse flags; load beats step beats hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_presc   <= '0;
            r_tc      <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_tc      <= 1'b0;
            r_loadErr <= 1'b0;
            if (load) begin
                if (w_loadOk) begin
                    r_count <= load_val;
                    r_presc <= '0;
                end else begin
                    r_loadErr <= 1'b1;
                end
            end else if (en) begin
                if (w_step) begin
                    r_presc <= '0;
`ifdef BCD_SATURATE_EN
                    if (w_carry[DIGITS]) begin
                        r_tc <= 1'b1;
                    end else begin
                        r_count <= w_next;
                    end
`else
                    r_count <= w_next;
                    r_tc    <= w_carry[DIGITS];
`endif
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign load_err = r_loadErr;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter. Two instances share
// the stimulus: one with TICK_DIV=1 and one with TICK_DIV=3.
// Honours BCD_SATURATE_EN when the build defines it.
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       load_err;
    logic [7:0] count3;
    logic       tc3;
    logic       loadErr3;

    int testCount = 0;
    int failCount = 0;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bcd_updown_counter #(.DIGITS(2), .TICK_DIV(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .load_err (load_err)
    );

    bcd_updown_counter #(.DIGITS(2), .TICK_DIV(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count3),
        .tc       (tc3),
        .load_err (loadErr3)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] heldVal;
        rst      = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        #3;
        checkOutput("reset count", 32'(count), 32'h00);
        checkOutput("reset tc", 32'(tc), 32'h0);
        checkOutput("reset load_err", 32'(load_err), 32'h0);
        rst = 1'b1;

        // Asynchronous reset in the middle of a count
        load = 1'b1; load_val = 8'h47;
        applyStimulus();
        checkOutput("load 47", 32'(count), 32'h47);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset count", 32'(count), 32'h00);
        checkOutput("async reset tc", 32'(tc), 32'h0);
        rst = 1'b1;
        applyStimulus();
        checkOutput("after release 01", 32'(count), 32'h01);
        applyStimulus();
        checkOutput("after release 02", 32'(count), 32'h02);

        // Up through the top limit
        en = 1'b0; load = 1'b1; load_val = 8'h98;
        applyStimulus();
        checkOutput("load 98", 32'(count), 32'h98);
        load = 1'b0; en = 1'b1; up = 1'b1;
        applyStimulus();
        checkOutput("up 99", 32'(count), 32'h99);
        checkOutput("up 99 tc", 32'(tc), 32'h0);
        applyStimulus();
        checkOutput("up limit count", 32'(count), SAT ? 32'h99 : 32'h00);
        checkOutput("up limit tc", 32'(tc), 32'h1);
        applyStimulus();
        checkOutput("up past limit", 32'(count), SAT ? 32'h99 : 32'h01);
        checkOutput("up past limit tc", 32'(tc), SAT ? 32'h1 : 32'h0);

        // Down with borrow, then down through zero
        en = 1'b0; load = 1'b1; load_val = 8'h10;
        applyStimulus();
        checkOutput("load 10", 32'(count), 32'h10);
        load = 1'b0; en = 1'b1; up = 1'b0;
        applyStimulus();
        checkOutput("down 09", 32'(count), 32'h09);
        applyStimulus();
        checkOutput("down 08", 32'(count), 32'h08);
        en = 1'b0; load = 1'b1; load_val = 8'h00;
        applyStimulus();
        checkOutput("load 00", 32'(count), 32'h00);
        load = 1'b0; en = 1'b1; up = 1'b0;
        applyStimulus();
        checkOutput("down limit count", 32'(count), SAT ? 32'h00 : 32'h99);
        checkOutput("down limit tc", 32'(tc), 32'h1);
        heldVal = SAT ? 8'h00 : 8'h99;

        // Rejected load of a non-BCD value, then a good load
        en = 1'b0; load = 1'b1; load_val = 8'h3A;
        applyStimulus();
        checkOutput("bad load count", 32'(count), 32'(heldVal));
        checkOutput("bad load err", 32'(load_err), 32'h1);
        load = 1'b0;
        applyStimulus();
        checkOutput("load_err pulse ends", 32'(load_err), 32'h0);
        load = 1'b1; load_val = 8'h35;
        applyStimulus();
        checkOutput("load 35", 32'(count), 32'h35);
        checkOutput("good load err", 32'(load_err), 32'h0);

        // Prescaler with TICK_DIV=3 and an en gap mid-period
        load_val = 8'h00;
        applyStimulus();
        checkOutput("div3 load 00", 32'(count3), 32'h00);
        load = 1'b0; en = 1'b1; up = 1'b1;
        applyStimulus();
        checkOutput("div3 edge1", 32'(count3), 32'h00);
        applyStimulus();
        checkOutput("div3 edge2", 32'(count3), 32'h00);
        applyStimulus();
        checkOutput("div3 edge3 step", 32'(count3), 32'h01);
        applyStimulus();
        applyStimulus();
        checkOutput("div3 edge5", 32'(count3), 32'h01);
        en = 1'b0;
        applyStimulus();
        checkOutput("div3 gap1", 32'(count3), 32'h01);
        applyStimulus();
        checkOutput("div3 gap2", 32'(count3), 32'h01);
        en = 1'b1;
        applyStimulus();
        checkOutput("div3 delayed step", 32'(count3), 32'h02);

        // Load collides with a qualifying step: load wins
        applyStimulus();
        applyStimulus();
        load = 1'b1; load_val = 8'h42;
        applyStimulus();
        checkOutput("div3 load beats step", 32'(count3), 32'h42);
        checkOutput("div1 load beats step", 32'(count), 32'h42);
        load = 1'b0;
        applyStimulus();
        checkOutput("div1 next step", 32'(count), 32'h43);
        checkOutput("div3 prescaler restarted 1", 32'(count3), 32'h42);
        applyStimulus();
        checkOutput("div3 prescaler restarted 2", 32'(count3), 32'h42);
        applyStimulus();
        checkOutput("div3 step after load", 32'(count3), 32'h43);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
